// File: rtl/kp_scan_debounce_if.sv
// -----------------------------------------------------------------------------
// kp_scan_debounce_if
// Bundles the keypad pin side (kpr/kpc) and the decoded key outputs of the
// keypad scanner into one interface.
//   master : keypad/consumer side - drives kpr, observes strobes and key outputs
//   slave  : scanner side         - samples kpr, drives kpc and key outputs
// Signals:
//   kpr       ROWS  row lines, active low
//   kpc       COLS  column strobes, active low, one-cold
//   key_code  KW    accepted key index (row*COLS + col)
//   key_valid 1     one-cycle pulse per accepted press or repeat
//   key_held  1     accepted key currently down
//   multi_err 1     stable frame shows more than one key down
// -----------------------------------------------------------------------------
interface kp_scan_debounce_if #(
    parameter int ROWS = 4,
    parameter int COLS = 4
);
    localparam int NK = ROWS * COLS;
    localparam int KW = (NK > 1) ? $clog2(NK) : 1;

    logic [ROWS-1:0] kpr;
    logic [COLS-1:0] kpc;
    logic [KW-1:0]   key_code;
    logic            key_valid;
    logic            key_held;
    logic            multi_err;

    modport master (
        output kpr,
        input  kpc,
        input  key_code,
        input  key_valid,
        input  key_held,
        input  multi_err
    );

    modport slave (
        input  kpr,
        output kpc,
        output key_code,
        output key_valid,
        output key_held,
        output multi_err
    );
endinterface

// File: rtl/kp_scan_debounce.sv
// -----------------------------------------------------------------------------
// kp_scan_debounce
// Keypad front end for a ROWS x COLS matrix: strobes one column low at a time,
// samples the (synchronised) active-low rows at the end of each column slot,
// assembles a frame, debounces whole frames and reports accepted keys with an
// optional auto-repeat.
// Ports:
//   clk      system clock
//   reset_n  synchronous reset, active low
//   kp       kp_scan_debounce_if.slave (kpr in; kpc, key_code, key_valid,
//            key_held, multi_err out - all outputs registered)
// -----------------------------------------------------------------------------
module kp_scan_debounce #(
    parameter int ROWS           = 4,
    parameter int COLS           = 4,
    parameter int SCAN_DIV       = 1000,
    parameter int DEBOUNCE_SCANS = 4,
    parameter bit REPEAT_EN      = 1'b0,
    parameter int REPEAT_DELAY   = 50,
    parameter int REPEAT_RATE    = 10
) (
    input  logic              clk,
    input  logic              reset_n,
    kp_scan_debounce_if.slave kp
);

    localparam int NK      = ROWS * COLS;
    localparam int KW      = (NK > 1) ? $clog2(NK) : 1;
    localparam int DIVW    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int COLW    = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int STW     = $clog2(DEBOUNCE_SCANS + 1);
    localparam int REP_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int RPW     = $clog2(REP_MAX + 1);

    localparam logic [DIVW-1:0] DIV_LAST = DIVW'(SCAN_DIV - 1);
    localparam logic [COLW-1:0] COL_LAST = COLW'(COLS - 1);
    localparam logic [STW-1:0]  ST_FULL  = STW'(DEBOUNCE_SCANS);

    typedef enum logic [1:0] {
        CAND_NONE  = 2'd0,
        CAND_KEY   = 2'd1,
        CAND_MULTI = 2'd2
    } cand_e;

    // One-cold strobe pattern for a given column index.
    function automatic logic [COLS-1:0] strobe_for(input logic [COLW-1:0] c);
        logic [COLS-1:0] s;
        s = '1;
        for (int i = 0; i < COLS; i++) begin
            if (COLW'(i) == c) begin
                s[i] = 1'b0;
            end
        end
        return s;
    endfunction

    // Registered state
    logic [ROWS-1:0] sync1_q, sync2_q;
    logic [DIVW-1:0] div_q, div_d;
    logic [COLW-1:0] col_q, col_d;
    logic [COLS-1:0] kpc_q, kpc_d;
    logic [NK-1:0]   frame_q, frame_d;
    cand_e           cand_kind_q, cand_kind_d;
    logic [KW-1:0]   cand_key_q, cand_key_d;
    logic [STW-1:0]  stable_q, stable_d;
    logic [RPW-1:0]  rep_cnt_q, rep_cnt_d;
    logic            rep_first_q, rep_first_d;
    logic [KW-1:0]   key_code_q, key_code_d;
    logic            key_valid_q, key_valid_d;
    logic            key_held_q, key_held_d;
    logic            multi_err_q, multi_err_d;

    // Combinational helpers
    logic            sample_s;
    logic            wrap_s;
    logic [NK-1:0]   frame_full_s;
    logic [1:0]      hits_s;
    logic [KW-1:0]   res_key_s;
    cand_e           res_kind_s;
    logic            same_s;
    logic [STW-1:0]  cnt_new_s;
    logic            reach_s;
    logic            rep_ok_s;
    logic [RPW-1:0]  rep_new_s;
    logic [RPW-1:0]  rep_target_s;

    // Scan timing: sample on the last cycle of a column slot, wrap after the last column.
    always_comb begin
        sample_s = (div_q == DIV_LAST);
        wrap_s   = sample_s && (col_q == COL_LAST);
    end

    // Current frame with this cycle's row sample merged in (pressed = 1).
    always_comb begin
        frame_full_s = frame_q;
        for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) begin
                if (sample_s && (COLW'(c) == col_q)) begin
                    frame_full_s[r*COLS + c] = ~sync2_q[r];
                end else begin
                    frame_full_s[r*COLS + c] = frame_q[r*COLS + c];
                end
            end
        end
    end

    // Classify the frame: count set bits (saturating at 2) and remember the index.
    always_comb begin
        hits_s    = 2'd0;
        res_key_s = '0;
        for (int i = 0; i < NK; i++) begin
            if (frame_full_s[i]) begin
                hits_s    = (hits_s == 2'd2) ? 2'd2 : hits_s + 2'd1;
                res_key_s = KW'(i);
            end else begin
                res_key_s = res_key_s;
            end
        end
        case (hits_s)
            2'd0:    res_kind_s = CAND_NONE;
            2'd1:    res_kind_s = CAND_KEY;
            default: res_kind_s = CAND_MULTI;
        endcase
    end

    // Debounce comparison and repeat eligibility for the frame being evaluated.
    always_comb begin
        same_s = (res_kind_s == cand_kind_q) &&
                 ((res_kind_s != CAND_KEY) || (res_key_s == cand_key_q));
        if (same_s) begin
            cnt_new_s = (stable_q == ST_FULL) ? stable_q : stable_q + STW'(1);
        end else begin
            cnt_new_s = STW'(1);
        end
        // Action fires only on the frame the count first hits the threshold.
        reach_s  = wrap_s && (cnt_new_s == ST_FULL) && ((stable_q != ST_FULL) || !same_s);
        // Repeat only counts frames after the accepting frame, with the held key still stable.
        rep_ok_s = wrap_s && same_s && (stable_q == ST_FULL) && (cand_kind_q == CAND_KEY) &&
                   (cand_key_q == key_code_q) && key_held_q;
        rep_new_s    = rep_cnt_q + RPW'(1);
        rep_target_s = rep_first_q ? RPW'(REPEAT_DELAY) : RPW'(REPEAT_RATE);
    end

    // Next-state for divider, column, frame, debounce, repeat and outputs.
    always_comb begin
        div_d       = sample_s ? '0 : div_q + DIVW'(1);
        col_d       = col_q;
        frame_d     = frame_full_s;
        cand_kind_d = cand_kind_q;
        cand_key_d  = cand_key_q;
        stable_d    = stable_q;
        rep_cnt_d   = rep_cnt_q;
        rep_first_d = rep_first_q;
        key_code_d  = key_code_q;
        key_held_d  = key_held_q;
        multi_err_d = multi_err_q;
        key_valid_d = 1'b0;

        if (sample_s) begin
            col_d = wrap_s ? '0 : col_q + COLW'(1);
        end else begin
            col_d = col_q;
        end
        kpc_d = strobe_for(col_d);

        if (wrap_s) begin
            frame_d     = '0;
            cand_kind_d = res_kind_s;
            cand_key_d  = res_key_s;
            stable_d    = cnt_new_s;

            if (reach_s) begin
                case (res_kind_s)
                    CAND_KEY: begin
                        multi_err_d = 1'b0;
                        if (!key_held_q || (res_key_s != key_code_q)) begin
                            key_code_d  = res_key_s;
                            key_held_d  = 1'b1;
                            key_valid_d = 1'b1;
                        end else begin
                            key_held_d = key_held_q;
                        end
                    end
                    CAND_NONE: begin
                        key_held_d  = 1'b0;
                        multi_err_d = 1'b0;
                    end
                    CAND_MULTI: begin
                        multi_err_d = 1'b1;
                    end
                    default: begin
                        multi_err_d = multi_err_q;
                    end
                endcase
            end else begin
                multi_err_d = multi_err_q;
            end

            if ((REPEAT_EN == 1'b1) && rep_ok_s) begin
                if (rep_new_s == rep_target_s) begin
                    key_valid_d = 1'b1;
                    rep_cnt_d   = '0;
                    rep_first_d = 1'b0;
                end else begin
                    rep_cnt_d = rep_new_s;
                end
            end else begin
                rep_cnt_d   = '0;
                rep_first_d = 1'b1;
            end
        end else begin
            frame_d = frame_full_s;
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sync1_q     <= '1;
            sync2_q     <= '1;
            div_q       <= '0;
            col_q       <= '0;
            kpc_q       <= strobe_for('0);
            frame_q     <= '0;
            cand_kind_q <= CAND_NONE;
            cand_key_q  <= '0;
            stable_q    <= '0;
            rep_cnt_q   <= '0;
            rep_first_q <= 1'b1;
            key_code_q  <= '0;
            key_valid_q <= 1'b0;
            key_held_q  <= 1'b0;
            multi_err_q <= 1'b0;
        end else begin
            sync1_q     <= kp.kpr;
            sync2_q     <= sync1_q;
            div_q       <= div_d;
            col_q       <= col_d;
            kpc_q       <= kpc_d;
            frame_q     <= frame_d;
            cand_kind_q <= cand_kind_d;
            cand_key_q  <= cand_key_d;
            stable_q    <= stable_d;
            rep_cnt_q   <= rep_cnt_d;
            rep_first_q <= rep_first_d;
            key_code_q  <= key_code_d;
            key_valid_q <= key_valid_d;
            key_held_q  <= key_held_d;
            multi_err_q <= multi_err_d;
        end
    end

    assign kp.kpc       = kpc_q;
    assign kp.key_code  = key_code_q;
    assign kp.key_valid = key_valid_q;
    assign kp.key_held  = key_held_q;
    assign kp.multi_err = multi_err_q;

endmodule

// File: tb/tb_kp_scan_debounce.sv
// -----------------------------------------------------------------------------
// tb_kp_scan_debounce
// Directed bench for kp_scan_debounce with SCAN_DIV=4, 4x4 matrix,
// DEBOUNCE_SCANS=3, REPEAT_DELAY=4, REPEAT_RATE=2 (frame = 16 clk).
// dut0 has auto-repeat off, dut1 has it on; both see the same key matrix
// through a small keypad model driven by each DUT's own column strobes.
// -----------------------------------------------------------------------------
module tb_kp_scan_debounce;

    logic        clk;
    logic        reset_n;
    logic [15:0] keys;      // bit r*4+c = key at row r, col c pressed

    int n_checks;
    int n_err;
    int pcnt0;
    int pcnt1;
    int cyc;
    int q1t[$];
    int q1c[$];

    kp_scan_debounce_if #(.ROWS(4), .COLS(4)) if0 ();
    kp_scan_debounce_if #(.ROWS(4), .COLS(4)) if1 ();

    kp_scan_debounce #(
        .ROWS(4), .COLS(4), .SCAN_DIV(4), .DEBOUNCE_SCANS(3),
        .REPEAT_EN(1'b0), .REPEAT_DELAY(4), .REPEAT_RATE(2)
    ) dut0 (
        .clk(clk), .reset_n(reset_n), .kp(if0)
    );

    kp_scan_debounce #(
        .ROWS(4), .COLS(4), .SCAN_DIV(4), .DEBOUNCE_SCANS(3),
        .REPEAT_EN(1'b1), .REPEAT_DELAY(4), .REPEAT_RATE(2)
    ) dut1 (
        .clk(clk), .reset_n(reset_n), .kp(if1)
    );

    // Keypad model: a row reads low when a pressed key sits on a strobed column.
    function automatic logic [3:0] rows_for(input logic [15:0] k, input logic [3:0] kpc);
        logic [3:0] rows;
        for (int r = 0; r < 4; r++) begin
            rows[r] = ~|(k[r*4 +: 4] & ~kpc);
        end
        return rows;
    endfunction

    assign if0.kpr = rows_for(keys, if0.kpc);
    assign if1.kpr = rows_for(keys, if1.kpc);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Cycle counter and pulse recorders.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (if0.key_valid === 1'b1) pcnt0 <= pcnt0 + 1;
        if (if1.key_valid === 1'b1) begin
            pcnt1 <= pcnt1 + 1;
            q1t.push_back(cyc);
            q1c.push_back(int'(if1.key_code));
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        int p0;
        int p1;
        int t0;
        int waited;
        logic [3:0] exp_kpc;

        n_checks = 0;
        n_err    = 0;
        pcnt0    = 0;
        pcnt1    = 0;
        cyc      = 0;
        keys     = 16'h0000;
        reset_n  = 1'b0;
        wait_cycles(3);

        // Reset state
        check_eq("rst_kpc", 32'(if0.kpc), 32'h0000_000e);
        check_eq("rst_code", 32'(if0.key_code), 32'h0);
        check_eq("rst_flags", {29'd0, if0.key_valid, if0.key_held, if0.multi_err}, 32'h0);

        // 1: column strobe sequence, idle outputs
        reset_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            exp_kpc = ~(4'b0001 << ((i / 4) % 4));
            check_eq($sformatf("t1_kpc_%0d", i), 32'(if0.kpc), 32'(exp_kpc));
            check_eq($sformatf("t1_flags_%0d", i),
                     {29'd0, if0.key_valid, if0.key_held, if0.multi_err}, 32'h0);
            @(negedge clk);
        end

        // 2: hold key 6 (row1/col2) for 5 frames
        p0 = pcnt0;
        keys[6] = 1'b1;
        wait_cycles(70);
        check_eq("t2_pulse_by_latency", 32'(pcnt0 - p0), 32'd1);
        wait_cycles(10);
        check_eq("t2_pulses", 32'(pcnt0 - p0), 32'd1);
        check_eq("t2_code", 32'(if0.key_code), 32'd6);
        check_eq("t2_held", 32'(if0.key_held), 32'd1);
        keys = 16'h0000;
        wait_cycles(80);
        check_eq("t2_rel_held", 32'(if0.key_held), 32'd0);
        check_eq("t2_rel_code", 32'(if0.key_code), 32'd6);
        check_eq("t2_rel_nopulse", 32'(pcnt0 - p0), 32'd1);

        // 3: key bouncing every frame, then released
        p0 = pcnt0;
        for (int f = 0; f < 6; f++) begin
            keys[6] = (f % 2 == 0);
            wait_cycles(16);
        end
        keys = 16'h0000;
        wait_cycles(80);
        check_eq("t3_pulses", 32'(pcnt0 - p0), 32'd0);
        check_eq("t3_held", 32'(if0.key_held), 32'd0);

        // 4: rows 0 and 2 low on col 1 (keys 1 and 9)
        p0 = pcnt0;
        keys[1] = 1'b1;
        keys[9] = 1'b1;
        wait_cycles(80);
        check_eq("t4_multi", 32'(if0.multi_err), 32'd1);
        check_eq("t4_pulses", 32'(pcnt0 - p0), 32'd0);
        check_eq("t4_held", 32'(if0.key_held), 32'd0);
        keys = 16'h0000;
        wait_cycles(80);
        check_eq("t4_multi_clr", 32'(if0.multi_err), 32'd0);
        check_eq("t4_rel_pulses", 32'(pcnt0 - p0), 32'd0);

        // 5: auto-repeat on dut1, key 5 (row1/col1)
        q1t.delete();
        q1c.delete();
        p0 = pcnt0;
        keys[5] = 1'b1;
        waited = 0;
        while (q1t.size() == 0 && waited < 120) begin
            @(negedge clk);
            waited++;
        end
        check_eq("t5_first_pulse_seen", 32'(q1t.size() > 0), 32'd1);
        if (q1t.size() > 0) begin
            t0 = q1t[0];
            wait_cycles(167);
            keys = 16'h0000;
            wait_cycles(80);
            check_eq("t5_pulse_count", 32'(q1t.size()), 32'd5);
            for (int k = 1; k < 5; k++) begin
                if (k < q1t.size()) begin
                    check_eq($sformatf("t5_gap_%0d", k), 32'(q1t[k] - t0), 32'(32 + 32 * k));
                end
            end
            for (int k = 0; k < q1c.size(); k++) begin
                check_eq($sformatf("t5_code_%0d", k), 32'(q1c[k]), 32'd5);
            end
            check_eq("t5_norepeat_dut0", 32'(pcnt0 - p0), 32'd1);
            check_eq("t5_rel_held", 32'(if1.key_held), 32'd0);
        end else begin
            keys = 16'h0000;
            wait_cycles(80);
        end

        // 6: key 3 then key 9 without a release in between, then reset mid-frame
        p0 = pcnt0;
        keys[3] = 1'b1;
        wait_cycles(80);
        check_eq("t6_code3", 32'(if0.key_code), 32'd3);
        keys = 16'h0000;
        keys[9] = 1'b1;
        wait_cycles(80);
        check_eq("t6_pulses", 32'(pcnt0 - p0), 32'd2);
        check_eq("t6_code9", 32'(if0.key_code), 32'd9);
        check_eq("t6_held", 32'(if0.key_held), 32'd1);
        wait_cycles(5);
        reset_n = 1'b0;
        p0 = pcnt0;
        p1 = pcnt1;
        @(negedge clk);
        check_eq("t6_rst_kpc", 32'(if0.kpc), 32'h0000_000e);
        check_eq("t6_rst_code", 32'(if0.key_code), 32'h0);
        check_eq("t6_rst_flags", {29'd0, if0.key_valid, if0.key_held, if0.multi_err}, 32'h0);
        check_eq("t6_rst_flags1", {29'd0, if1.key_valid, if1.key_held, if1.multi_err}, 32'h0);
        wait_cycles(4);
        check_eq("t6_rst_nopulse", 32'((pcnt0 - p0) + (pcnt1 - p1)), 32'd0);
        check_eq("t6_rst_kpc_hold", 32'(if1.kpc), 32'h0000_000e);
        keys = 16'h0000;
        reset_n = 1'b1;
        wait_cycles(2);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
